lpif_txrx_x8_asym2_half_slave_gearbox: RTL and testbench
========================================================

LPIF_TXRX_X8_ASYM2_HALF_SLAVE_GEARBOX -- requirements
Module: lpif_txrx_x8_asym2_half_slave_gearbox

Interface
REQ-001 Parameter PACK_FLUSH_CYCLES, default 0; idle cycles before a lone upstream lo beat is flushed; 0 disables flush.
REQ-002 clk_wr  input  1  single block clock; all logic synchronous to it.
REQ-003 rst_wr_n  input  1  asynchronous active-low reset.
REQ-004 rxfifo_downstream_data  input  290  packed word; lo beat bits [144:0], hi beat bits [289:145].
REQ-005 rxfifo_downstream_vld / rxfifo_downstream_rd  input / output  1 / 1  word valid and word pop.
REQ-006 dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid, dstrm_crc, dstrm_crc_valid, dstrm_valid  output  4, 2, 128, 1, 8, 1, 1  full-rate beat.
REQ-007 Per-beat field order, LSB first: state[3:0], protid[1:0], data[127:0], dvalid, crc[7:0], crc_valid, valid (145 bits).
REQ-008 ustrm_state, ustrm_protid, ustrm_data, ustrm_dvalid, ustrm_crc, ustrm_crc_valid, ustrm_valid  input  4, 2, 128, 1, 8, 1, 1  full-rate beat.
REQ-009 txfifo_upstream_data  output  290  packed word, same layout as REQ-004.
REQ-010 txfifo_upstream_push  output  1  one-cycle strobe; word valid.
REQ-011 frame_err_cnt  output  8  framing error count (see Configuration).

Function
REQ-012 Unpack FSM states: EMPTY, LO, HI.
REQ-013 EMPTY: rxfifo_downstream_rd = rxfifo_downstream_vld; on pop, capture word into 290-bit holding register, next state LO; dstrm_* driven 0.
REQ-014 LO: drive registered lo beat on dstrm_*; next state HI.
REQ-015 HI: drive hi beat; pop next word in same cycle if vld (next LO), else next EMPTY.
REQ-016 Back-to-back words SHALL yield gap-free beats; latency word pop -> first beat = 1 cycle.
REQ-017 All dstrm_* outputs registered; dstrm_* = 0 whenever FSM not in LO/HI.
REQ-018 Pack FSM states: WAIT_LO, WAIT_HI.
REQ-019 WAIT_LO: cycle with ustrm_valid=1 captures beat into lo half, next WAIT_HI; ustrm_valid=0 beats discarded.
REQ-020 WAIT_HI: ustrm_valid=1 beat forms hi half; txfifo_upstream_push=1 next cycle with full word; next WAIT_LO.
REQ-021 WAIT_HI with ustrm_valid=0: lo held, idle counter increments.
REQ-022 PACK_FLUSH_CYCLES>0 and idle counter reaches it: push word with hi half all zero, return WAIT_LO, counter cleared.
REQ-023 Idle counter width ceil(log2(PACK_FLUSH_CYCLES+1)), minimum 1; cleared on every valid beat.
REQ-024 txfifo_upstream_data holds last pushed word between pushes.
REQ-025 No backpressure on ustrm path; downstream FIFO is sized by integrator.

Reset
REQ-026 rst_wr_n low: unpack FSM -> EMPTY, pack FSM -> WAIT_LO, holding registers, idle counter, frame_err_cnt, all outputs -> 0, immediately.
REQ-027 Reset mid-word: partial holding data discarded; no push or pop asserted in first cycle after deassertion.

Configuration
REQ-028 Macro LPIF_GEARBOX_FRAME_ERR_EN.
REQ-029 Defined: frame_err_cnt increments, saturating at 255, each popped word whose hi-beat valid=1 with lo-beat valid=0.
REQ-030 Undefined: no counter logic; frame_err_cnt tied 0; all other behaviour identical.

Verification
REQ-031 Two back-to-back words, vld held 2 cycles -> four consecutive dstrm beats lo0,hi0,lo1,hi1, rd pulses in EMPTY and HI cycles.
REQ-032 ustrm_valid pattern 1,0,0,1 with data 0xA5.., 0x5A.. -> single push, lo=0xA5.. beat, hi=0x5A.. beat.
REQ-033 PACK_FLUSH_CYCLES=3, one valid beat then idle -> push on 4th idle cycle, bits [289:145]=0.
REQ-034 Reset asserted in HI state -> dstrm_valid=0, rd=0 same cycle; clean restart on next word.
REQ-035 Macro defined, 300 words with lo valid=0, hi valid=1 -> frame_err_cnt=255; macro undefined -> 0.

Source files
------------

// File: rtl/lpif_txrx_x8_asym2_half_slave_gearbox_if.sv
// Bus bundle for the x8 half-rate gearbox: RX FIFO pop side, full-rate downstream
// beats, full-rate upstream beats, TX FIFO push side and the framing error count.
interface lpif_txrx_x8_asym2_half_slave_gearbox_if;
    logic [289:0] rxfifo_downstream_data;
    logic         rxfifo_downstream_vld;
    logic         rxfifo_downstream_rd;

    logic [3:0]   dstrm_state;
    logic [1:0]   dstrm_protid;
    logic [127:0] dstrm_data;
    logic         dstrm_dvalid;
    logic [7:0]   dstrm_crc;
    logic         dstrm_crc_valid;
    logic         dstrm_valid;

    logic [3:0]   ustrm_state;
    logic [1:0]   ustrm_protid;
    logic [127:0] ustrm_data;
    logic         ustrm_dvalid;
    logic [7:0]   ustrm_crc;
    logic         ustrm_crc_valid;
    logic         ustrm_valid;

    logic [289:0] txfifo_upstream_data;
    logic         txfifo_upstream_push;
    logic [7:0]   frame_err_cnt;

    modport slave (
        input  rxfifo_downstream_data, rxfifo_downstream_vld,
        output rxfifo_downstream_rd,
        output dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid,
        output dstrm_crc, dstrm_crc_valid, dstrm_valid,
        input  ustrm_state, ustrm_protid, ustrm_data, ustrm_dvalid,
        input  ustrm_crc, ustrm_crc_valid, ustrm_valid,
        output txfifo_upstream_data, txfifo_upstream_push,
        output frame_err_cnt
    );

    modport master (
        output rxfifo_downstream_data, rxfifo_downstream_vld,
        input  rxfifo_downstream_rd,
        input  dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid,
        input  dstrm_crc, dstrm_crc_valid, dstrm_valid,
        output ustrm_state, ustrm_protid, ustrm_data, ustrm_dvalid,
        output ustrm_crc, ustrm_crc_valid, ustrm_valid,
        input  txfifo_upstream_data, txfifo_upstream_push,
        input  frame_err_cnt
    );
endinterface

// File: rtl/lpif_txrx_x8_asym2_half_slave_gearbox.sv
// Two-beat gearbox: unpacks 290-bit RX FIFO words into full-rate beats and packs beats
// into TX FIFO words. Define LPIF_GEARBOX_FRAME_ERR_EN to build the framing error counter.
module lpif_txrx_x8_asym2_half_slave_gearbox #(
    parameter int PACK_FLUSH_CYCLES = 0
) (
    input  logic clk_wr,
    input  logic rst_wr_n,
    lpif_txrx_x8_asym2_half_slave_gearbox_if.slave bus
);

    localparam int BEAT_W = 145;
    localparam int WORD_W = 2 * BEAT_W;
    localparam int IDLE_W = (PACK_FLUSH_CYCLES > 0) ? $clog2(PACK_FLUSH_CYCLES + 1) : 1;
    localparam logic [IDLE_W-1:0] FLUSH_LAST = IDLE_W'(PACK_FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {EMPTY, LO, HI} unpack_state_t;
    typedef enum logic {WAIT_LO, WAIT_HI} pack_state_t;

    unpack_state_t     un_state_q, un_state_d;
    logic [BEAT_W-1:0] hold_q, hold_d;
    logic [BEAT_W-1:0] dstrm_q, dstrm_d;
    logic              started_q, started_d;
    logic              pop;

    pack_state_t       pk_state_q, pk_state_d;
    logic [BEAT_W-1:0] lo_q, lo_d;
    logic [WORD_W-1:0] tx_data_q, tx_data_d;
    logic              push_q, push_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [BEAT_W-1:0] ubeat;

    // Keeps the pop strobe low for the first cycle after reset release.
    always_comb begin
        started_d = 1'b1;
    end

    // Unpack: the lo half goes straight into the output register on pop, so only the
    // hi half has to wait in the holding register.
    always_comb begin
        un_state_d = un_state_q;
        hold_d     = hold_q;
        dstrm_d    = '0;
        pop        = 1'b0;
        case (un_state_q)
            EMPTY: begin
                pop = started_q & bus.rxfifo_downstream_vld;
                if (pop) begin
                    hold_d     = bus.rxfifo_downstream_data[WORD_W-1:BEAT_W];
                    dstrm_d    = bus.rxfifo_downstream_data[BEAT_W-1:0];
                    un_state_d = LO;
                end
            end
            LO: begin
                dstrm_d    = hold_q;
                un_state_d = HI;
            end
            HI: begin
                pop = started_q & bus.rxfifo_downstream_vld;
                if (pop) begin
                    hold_d     = bus.rxfifo_downstream_data[WORD_W-1:BEAT_W];
                    dstrm_d    = bus.rxfifo_downstream_data[BEAT_W-1:0];
                    un_state_d = LO;
                end else begin
                    un_state_d = EMPTY;
                end
            end
            default: un_state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            un_state_q <= EMPTY;
            hold_q     <= '0;
            dstrm_q    <= '0;
            started_q  <= 1'b0;
        end else begin
            un_state_q <= un_state_d;
            hold_q     <= hold_d;
            dstrm_q    <= dstrm_d;
            started_q  <= started_d;
        end
    end

    assign bus.rxfifo_downstream_rd = pop;
    assign bus.dstrm_state          = dstrm_q[3:0];
    assign bus.dstrm_protid         = dstrm_q[5:4];
    assign bus.dstrm_data           = dstrm_q[133:6];
    assign bus.dstrm_dvalid         = dstrm_q[134];
    assign bus.dstrm_crc            = dstrm_q[142:135];
    assign bus.dstrm_crc_valid      = dstrm_q[143];
    assign bus.dstrm_valid          = dstrm_q[144];

    assign ubeat = {bus.ustrm_valid, bus.ustrm_crc_valid, bus.ustrm_crc, bus.ustrm_dvalid,
                    bus.ustrm_data, bus.ustrm_protid, bus.ustrm_state};

    // Pack: a lone lo beat is either completed by the next valid beat or, when the
    // flush timeout is enabled, pushed with a zero hi half once the idle count expires.
    always_comb begin
        pk_state_d = pk_state_q;
        lo_d       = lo_q;
        tx_data_d  = tx_data_q;
        push_d     = 1'b0;
        idle_d     = idle_q;
        case (pk_state_q)
            WAIT_LO: begin
                if (bus.ustrm_valid) begin
                    lo_d       = ubeat;
                    idle_d     = '0;
                    pk_state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (bus.ustrm_valid) begin
                    tx_data_d  = {ubeat, lo_q};
                    push_d     = 1'b1;
                    idle_d     = '0;
                    pk_state_d = WAIT_LO;
                end else if ((PACK_FLUSH_CYCLES > 0) && (idle_q == FLUSH_LAST)) begin
                    tx_data_d  = {{BEAT_W{1'b0}}, lo_q};
                    push_d     = 1'b1;
                    idle_d     = '0;
                    pk_state_d = WAIT_LO;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            default: pk_state_d = WAIT_LO;
        endcase
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            pk_state_q <= WAIT_LO;
            lo_q       <= '0;
            tx_data_q  <= '0;
            push_q     <= 1'b0;
            idle_q     <= '0;
        end else begin
            pk_state_q <= pk_state_d;
            lo_q       <= lo_d;
            tx_data_q  <= tx_data_d;
            push_q     <= push_d;
            idle_q     <= idle_d;
        end
    end

    assign bus.txfifo_upstream_data = tx_data_q;
    assign bus.txfifo_upstream_push = push_q;

`ifdef LPIF_GEARBOX_FRAME_ERR_EN
    logic [7:0] ferr_q, ferr_d;

    // A word whose hi beat is valid but whose lo beat is not means the beat pairing slipped.
    always_comb begin
        ferr_d = ferr_q;
        if (pop && bus.rxfifo_downstream_data[WORD_W-1] && !bus.rxfifo_downstream_data[BEAT_W-1]
            && (ferr_q != 8'hFF)) begin
            ferr_d = ferr_q + 8'd1;
        end
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            ferr_q <= 8'd0;
        end else begin
            ferr_q <= ferr_d;
        end
    end

    assign bus.frame_err_cnt = ferr_q;
`else
    assign bus.frame_err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_lpif_txrx_x8_asym2_half_slave_gearbox.sv
// Scoreboard bench for the x8 gearbox: stimulus queues expected beats/words, monitors
// pop and compare whenever the DUT presents a valid beat or a push.
module tb_lpif_txrx_x8_asym2_half_slave_gearbox;

    typedef logic [144:0] beat_t;
    typedef logic [289:0] word_t;

    logic clk_wr = 1'b0;
    logic rst_wr_n = 1'b0;
    always #5 clk_wr = ~clk_wr;

    lpif_txrx_x8_asym2_half_slave_gearbox_if bus ();

    lpif_txrx_x8_asym2_half_slave_gearbox #(.PACK_FLUSH_CYCLES(3)) u_dut (
        .clk_wr   (clk_wr),
        .rst_wr_n (rst_wr_n),
        .bus      (bus)
    );

`ifdef LPIF_GEARBOX_FRAME_ERR_EN
    localparam logic [7:0] EXP_FERR = 8'd255;
`else
    localparam logic [7:0] EXP_FERR = 8'd0;
`endif

    int    nchecks = 0;
    int    nerr = 0;
    beat_t exp_d[$];
    word_t exp_u[$];
    word_t rxq[$];
    logic  rd_s;

    function automatic beat_t mkbeat(logic v, logic [127:0] d, logic [7:0] tag);
        return {v, tag[0], tag, 1'b1, d, tag[1:0], tag[3:0]};
    endfunction

    function automatic beat_t dbeat();
        return {bus.dstrm_valid, bus.dstrm_crc_valid, bus.dstrm_crc, bus.dstrm_dvalid,
                bus.dstrm_data, bus.dstrm_protid, bus.dstrm_state};
    endfunction

    task automatic check(input string name, input word_t act, input word_t exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fifo_drive();
        bus.rxfifo_downstream_vld  = (rxq.size() > 0);
        bus.rxfifo_downstream_data = (rxq.size() > 0) ? rxq[0] : '0;
    endtask

    task automatic drive_u(input beat_t b);
        bus.ustrm_state     = b[3:0];
        bus.ustrm_protid    = b[5:4];
        bus.ustrm_data      = b[133:6];
        bus.ustrm_dvalid    = b[134];
        bus.ustrm_crc       = b[142:135];
        bus.ustrm_crc_valid = b[143];
        bus.ustrm_valid     = b[144];
    endtask

    // RX FIFO model: pops at the edge where the DUT held rd high.
    initial begin
        rd_s = 1'b0;
        forever begin
            @(negedge clk_wr);
            rd_s = bus.rxfifo_downstream_rd;
            @(posedge clk_wr);
            #1;
            if (rd_s && rxq.size() > 0) void'(rxq.pop_front());
            fifo_drive();
        end
    end

    // Monitor
    initial begin
        forever begin
            @(negedge clk_wr);
            if (rst_wr_n) begin
                if (bus.dstrm_valid) begin
                    if (exp_d.size() == 0) begin
                        nchecks++;
                        nerr++;
                        $display("FAIL dstrm_extra: got %h expected no beat", dbeat());
                    end else begin
                        check("dstrm_beat", word_t'(dbeat()), word_t'(exp_d.pop_front()));
                    end
                end
                if (bus.txfifo_upstream_push) begin
                    if (exp_u.size() == 0) begin
                        nchecks++;
                        nerr++;
                        $display("FAIL push_extra: got %h expected no push", bus.txfifo_upstream_data);
                    end else begin
                        check("push_word", bus.txfifo_upstream_data, exp_u.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        beat_t a, b, c, lo_r, hi_r, lo_s, hi_s;
        logic [4:0] exp_rd, exp_v;
        int k;
        fifo_drive();
        drive_u('0);

        // Reset state
        repeat (3) @(posedge clk_wr);
        #2;
        check("rst_dstrm", word_t'(dbeat()), '0);
        check("rst_push", word_t'(bus.txfifo_upstream_push), '0);
        check("rst_txdata", bus.txfifo_upstream_data, '0);
        check("rst_ferr", word_t'(bus.frame_err_cnt), '0);
        rst_wr_n = 1'b1;
        repeat (2) @(posedge clk_wr);

        // Two back-to-back words: gap-free lo0,hi0,lo1,hi1 and rd in EMPTY/HI cycles
        a = mkbeat(1'b1, 128'h0123_4567_89ab_cdef_0011_2233_4455_6677, 8'h11);
        b = mkbeat(1'b1, 128'hfedc_ba98_7654_3210_8899_aabb_ccdd_eeff, 8'h22);
        c = mkbeat(1'b1, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 8'h33);
        lo_s = mkbeat(1'b1, 128'h9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0000, 8'h44);
        @(posedge clk_wr);
        #2;
        rxq.push_back({b, a});
        rxq.push_back({lo_s, c});
        exp_d.push_back(a); exp_d.push_back(b); exp_d.push_back(c); exp_d.push_back(lo_s);
        fifo_drive();
        exp_rd = 5'b00101;
        exp_v  = 5'b11110;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_wr);
            check($sformatf("b2b_rd_%0d", i), word_t'(bus.rxfifo_downstream_rd), word_t'(exp_rd[i]));
            check($sformatf("b2b_valid_%0d", i), word_t'(bus.dstrm_valid), word_t'(exp_v[i]));
        end
        @(negedge clk_wr);
        check("empty_dstrm_zero", word_t'(dbeat()), '0);

        // Upstream pack: valid 1,0,0,1 -> one push {B,A}
        a = mkbeat(1'b1, {4{32'hA5A5_A5A5}}, 8'hA5);
        b = mkbeat(1'b1, {4{32'h5A5A_5A5A}}, 8'h5A);
        exp_u.push_back({b, a});
        @(posedge clk_wr); #2; drive_u(a);
        @(posedge clk_wr); #2; drive_u(mkbeat(1'b0, {4{32'hDEAD_BEEF}}, 8'hEE));
        @(posedge clk_wr); #2; drive_u(mkbeat(1'b0, {4{32'hCAFE_F00D}}, 8'hCC));
        @(posedge clk_wr); #2; drive_u(b);
        @(negedge clk_wr);
        check("pack_push_early", word_t'(bus.txfifo_upstream_push), '0);
        @(posedge clk_wr); #2; drive_u('0);
        @(negedge clk_wr);
        check("pack_push", word_t'(bus.txfifo_upstream_push), 1);
        @(posedge clk_wr); #2;
        @(negedge clk_wr);
        check("pack_push_one_cycle", word_t'(bus.txfifo_upstream_push), '0);
        check("pack_data_hold", bus.txfifo_upstream_data, {b, a});

        // Flush: one valid beat then idle -> push on 4th idle cycle with zero hi half
        c = mkbeat(1'b1, 128'h0f0f_0f0f_1234_5678_9abc_def0_5555_aaaa, 8'h3C);
        exp_u.push_back({145'b0, c});
        @(posedge clk_wr); #2; drive_u(c);
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk_wr); #2; drive_u('0);
            @(negedge clk_wr);
            check($sformatf("flush_push_idle%0d", i), word_t'(bus.txfifo_upstream_push),
                  word_t'(i == 4));
        end
        check("flush_data_hold", bus.txfifo_upstream_data, {145'b0, c});

        // Reset asserted in HI state
        lo_r = mkbeat(1'b1, 128'h7777_0000_7777_0000_7777_0000_7777_0000, 8'h71);
        hi_r = mkbeat(1'b1, 128'h8888_0000_8888_0000_8888_0000_8888_0000, 8'h72);
        lo_s = mkbeat(1'b1, 128'h1357_9bdf_2468_ace0_1357_9bdf_2468_ace0, 8'h73);
        hi_s = mkbeat(1'b1, 128'h0246_8ace_1357_9bdf_0246_8ace_1357_9bdf, 8'h74);
        @(posedge clk_wr); #2;
        rxq.push_back({hi_r, lo_r});
        rxq.push_back({hi_s, lo_s});
        exp_d.push_back(lo_r);
        fifo_drive();
        @(posedge clk_wr);
        @(posedge clk_wr);
        #2;
        rst_wr_n = 1'b0;
        #1;
        check("rst_hi_valid", word_t'(bus.dstrm_valid), '0);
        check("rst_hi_rd", word_t'(bus.rxfifo_downstream_rd), '0);
        repeat (2) @(posedge clk_wr);
        #2;
        exp_d.push_back(lo_s);
        exp_d.push_back(hi_s);
        rst_wr_n = 1'b1;
        #1;
        check("rd_first_cycle_after_reset", word_t'(bus.rxfifo_downstream_rd), '0);
        check("push_first_cycle_after_reset", word_t'(bus.txfifo_upstream_push), '0);
        repeat (6) @(posedge clk_wr);

        // Framing errors: 300 words with lo valid=0, hi valid=1
        @(posedge clk_wr); #2;
        for (int i = 0; i < 300; i++) begin
            a = mkbeat(1'b0, 128'(i), 8'(i));
            b = mkbeat(1'b1, ~128'(i), 8'(i + 1));
            rxq.push_back({b, a});
            exp_d.push_back(b);
        end
        fifo_drive();

        k = 0;
        while ((exp_d.size() != 0 || exp_u.size() != 0) && k < 3000) begin
            @(posedge clk_wr);
            k++;
        end
        if (exp_d.size() != 0 || exp_u.size() != 0) begin
            nchecks++;
            nerr++;
            $display("FAIL drain_timeout: got %0d/%0d pending expected 0/0", exp_d.size(), exp_u.size());
        end
        repeat (3) @(posedge clk_wr);
        #2;
        check("frame_err_cnt", word_t'(bus.frame_err_cnt), word_t'(EXP_FERR));
        check("idle_dstrm_zero", word_t'(dbeat()), '0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
